// File: rtl/seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_adder_ctrl
// Purpose  : Multi-cycle adder sequencer. Produces a WIDTH-bit sum a+b+cin by
//            reusing one CHUNK-wide ripple-carry slice over WIDTH/CHUNK cycles,
//            least significant chunk first. The carry between chunks is held
//            in a register.
// Ports    : clk   - clock, all state changes on the rising edge
//            rst   - synchronous active-high reset
//            start - request pulse, sampled only while busy=0
//            a, b  - operands, captured on the accepting edge
//            cin   - carry into chunk 0, captured on the accepting edge
//            busy  - high while an addition is in progress
//            done  - one-cycle pulse, sum/cout valid from this cycle
//            sum   - last completed result
//            cout  - carry out of the top chunk of the last completed result
// Revision : 1.0 - initial release
// ============================================================================
module seq_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    // Index register is at least one bit wide so a single-chunk build stays legal.
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_chunk_sum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    // Chunk selection and accumulator update are written as a decoded mux over
    // constant slices so no variable part-select is needed.
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        for (int k = 0; k < c_num_chunks; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < c_num_chunks; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_acc_next[k*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    assign w_last = (r_idx == c_last_idx);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    // sum/cout are only written here, as a whole, so partial
                    // results never reach the outputs.
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_chunk_sum[CHUNK];
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
